// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment constants are active high, bit order g..a.
package hex_scan_pkg;

  localparam int NDIG_DEFAULT = 4;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_bcd_dec.sv
// Combinational BCD to active-high 7-segment decoder (g..a).
// Codes above 9 produce a blank digit.
module seg7_bcd_dec
  import hex_scan_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves o_seg unassigned (no latch).
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Multiplexed NDIG-digit 7-segment scanner with dead-time blanking and a
// frame-synchronous double-buffered load port. Define LZ_BLANK_EN for leading-zero suppression.
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int NDIG      = NDIG_DEFAULT,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*NDIG-1:0]   load_data,
  input  logic [NDIG-1:0]     load_dp,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [NDIG-1:0]     dig_n,
  output logic                frame_done
);

  localparam int IDX_W   = $clog2(NDIG);
  localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

  scan_state_t             r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;

  logic [NDIG-1:0][3:0]    r_disp_data;
  logic [NDIG-1:0]         r_disp_dp;
  logic [NDIG-1:0][3:0]    r_shadow_data;
  logic [NDIG-1:0]         r_shadow_dp;
  logic                    r_pending;

  logic [6:0]              r_seg_n;
  logic                    r_dp_n;
  logic [NDIG-1:0]         r_dig_n;
  logic                    r_frame_done;

  logic                    w_boundary;
  logic                    w_accept;
  logic [3:0]              w_cur_bcd;
  logic [6:0]              w_seg;
  logic [NDIG-1:0]         w_dig_sel;
  logic [NDIG-1:0]         w_lz_mask;

  assign w_boundary = (r_state == BLANK) && (r_cnt == BLANK_LAST) && (r_idx == IDX_LAST);
  assign w_accept   = load_valid && !r_pending;
  assign w_cur_bcd  = r_disp_data[r_idx];
  assign w_dig_sel  = ~(NDIG'(1) << r_idx);

  seg7_bcd_dec u_dec (
    .i_bcd (w_cur_bcd),
    .o_seg (w_seg)
  );

`ifdef LZ_BLANK_EN
  // Mask bit i is set when digit i and every digit above it are zero; digit 0 always shows.
  logic w_upper_zero;
  always_comb begin
    w_lz_mask    = '0;
    w_upper_zero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      w_upper_zero = w_upper_zero && (r_disp_data[i] == 4'd0);
      w_lz_mask[i] = w_upper_zero;
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SHOW;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_seg_n      <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_dig_n      <= '1;
      r_frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, like real flops.
      r_frame_done <= w_boundary;
      case (r_state)
        SHOW: begin
          r_dig_n <= w_dig_sel;
          r_seg_n <= w_lz_mask[r_idx] ? ~SEG_OFF : ~w_seg;
          r_dp_n  <= ~r_disp_dp[r_idx];
          if (r_cnt == SHOW_LAST) begin
            r_state <= BLANK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BLANK: begin
          r_dig_n <= '1;
          r_seg_n <= 7'h7F;
          r_dp_n  <= 1'b1;
          if (r_cnt == BLANK_LAST) begin
            r_state <= SHOW;
            r_cnt   <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Shadow buffer: at most one pending value; it replaces the display only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: display/shadow storage is reset because a blank or stale frame after reset must be defined.
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_pending     <= 1'b0;
    end else if (w_boundary && r_pending) begin
      r_disp_data <= r_shadow_data;
      r_disp_dp   <= r_shadow_dp;
      r_pending   <= 1'b0;
    end else if (w_accept) begin
      r_shadow_data <= load_data;
      r_shadow_dp   <= load_dp;
      r_pending     <= 1'b1;
    end
  end

  assign load_ready = ~r_pending;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign dig_n      = r_dig_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (NDIG=4, DIV=4, BLANK_CYC=2) against a
// frame-phase reference model; honours LZ_BLANK_EN when defined.
module tb_hex_scan_ctrl;

  localparam int NDIG      = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
  localparam int PER       = DIV + BLANK_CYC;
  localparam int FRAME     = NDIG * PER;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  dig_n;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  // Reference model: the state before edge k is frame phase (k mod FRAME);
  // digit = phase / PER, lit while phase mod PER < DIV.
  int          m_t;
  logic [15:0] m_disp, m_shad;
  logic [3:0]  m_dp, m_shad_dp;
  logic        m_pend;
  logic [11:0] m_out;
  logic        m_fd;

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [11:0] expect_out(input int p, input logic [15:0] d, input logic [3:0] dp);
    int dg;
    logic [3:0] code;
    logic [6:0] seg;
    dg = p / PER;
    if ((p % PER) >= DIV) return {7'h7F, 1'b1, 4'hF};
    code = 4'((d >> (4 * dg)) & 16'h000F);
    seg  = (code <= 4'd9) ? ~seg_of(code) : 7'h7F;
`ifdef LZ_BLANK_EN
    if (dg != 0 && (d >> (4 * dg)) == 16'h0000) seg = 7'h7F;
`endif
    return {seg, ~dp[dg], ~(4'b0001 << dg)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_disp <= '0; m_shad <= '0; m_dp <= '0; m_shad_dp <= '0;
      m_pend <= 1'b0; m_out <= {7'h7F, 1'b1, 4'hF}; m_fd <= 1'b0;
    end else begin
      m_t   <= m_t + 1;
      m_out <= expect_out(m_t % FRAME, m_disp, m_dp);
      m_fd  <= (m_t % FRAME) == FRAME - 1;
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_disp <= m_shad; m_dp <= m_shad_dp; m_pend <= 1'b0;
      end else if (load_valid && !m_pend) begin
        m_shad <= load_data; m_shad_dp <= load_dp; m_pend <= 1'b1;
      end
    end
  end

  logic [13:0] dut_vec, exp_vec;
  assign dut_vec = {seg_n, dp_n, dig_n, frame_done, load_ready};
  assign exp_vec = {m_out, m_fd, ~m_pend};

  // Producer: queue of {dp, data}; holds load_valid until the handshake completes.
  logic [19:0] q[$];
  logic        was_ready = 1'b1;

  task automatic prod_step();
    if (load_valid && was_ready) begin
      load_valid = 1'b0;
      void'(q.pop_front());
    end
    if (!load_valid && q.size() != 0) begin
      load_valid = 1'b1;
      {load_dp, load_data} = q[0];
    end
    was_ready = load_ready;
  endtask

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];

  task automatic capture();
    for (int d = 0; d < 4; d++)
      if (dig_n == ~(4'b0001 << d)) begin
        cap_seg[d] = seg_n;
        cap_dp[d]  = dp_n;
      end
  endtask

  task automatic clear_capture();
    for (int d = 0; d < 4; d++) begin
      cap_seg[d] = 'x;
      cap_dp[d]  = 1'bx;
    end
  endtask

  task automatic test_reset();
    logic [3:0] seq [7];
    seq[0] = 4'hE; seq[1] = 4'hE; seq[2] = 4'hE; seq[3] = 4'hE;
    seq[4] = 4'hF; seq[5] = 4'hF; seq[6] = 4'hD;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (dut_vec !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_idle got=%h want=%h", dut_vec, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (dig_n !== seq[i] || dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL reset_scan cyc=%0d dig_n=%h want=%h vec=%h model=%h", i, dig_n, seq[i], dut_vec, exp_vec);
      end
      prod_step();
    end
  endtask

  task automatic test_load();
    int last_fd = -1;
    logic [6:0] es [4];
    logic       ed [4];
    es[0] = ~7'h66; es[1] = ~7'h4F; es[2] = ~7'h5B; es[3] = ~7'h06;
    ed[0] = 1'b1;   ed[1] = 1'b0;   ed[2] = 1'b1;   ed[3] = 1'b1;
    q.push_back({4'b0010, 16'h1234});
    clear_capture();
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL load_1234 t=%0d got=%h want=%h", m_t, dut_vec, exp_vec);
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          total++;
          if (m_t - last_fd != FRAME) begin
            bad++; $display("FAIL frame_period got=%0d want=%0d", m_t - last_fd, FRAME);
          end
        end
        last_fd = m_t;
      end
      if (k >= 2 * FRAME) capture();
      prod_step();
    end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (cap_seg[d] !== es[d] || cap_dp[d] !== ed[d]) begin
        bad++;
        $display("FAIL load_1234_dig%0d got seg_n=%h dp_n=%b want seg_n=%h dp_n=%b", d, cap_seg[d], cap_dp[d], es[d], ed[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    logic [6:0] es [4];
    es[0] = ~7'h5B; es[1] = ~7'h06; es[2] = ~7'h3F; es[3] = ~7'h6F;
    q.push_back({4'b0001, 16'h5678});
    q.push_back({4'b1000, 16'h9012});
    clear_capture();
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL back_to_back t=%0d got=%h want=%h", m_t, dut_vec, exp_vec);
      end
      if (load_valid && !load_ready) stalls++;
      if (k >= 3 * FRAME) capture();
      prod_step();
    end
    total++;
    if (stalls == 0) begin
      bad++; $display("FAIL back_pressure stall_cycles got=0 want>0");
    end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (cap_seg[d] !== es[d] || cap_dp[d] !== (d != 3)) begin
        bad++;
        $display("FAIL b_shown_dig%0d got seg_n=%h dp_n=%b want seg_n=%h dp_n=%b", d, cap_seg[d], cap_dp[d], es[d], d != 3);
      end
    end
  endtask

  task automatic test_boundary_load();
    bit pushed = 0;
    int fd_seen = 0;
    for (int k = 0; k < 3 * FRAME && !pushed; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL boundary_wait t=%0d got=%h want=%h", m_t, dut_vec, exp_vec);
      end
      if ((m_t % FRAME) == FRAME - 1 && q.size() == 0 && !load_valid && !m_pend) begin
        q.push_back({4'b0100, 16'h0705});
        pushed = 1;
      end
      prod_step();
    end
    total++;
    if (!pushed) begin
      bad++; $display("FAIL boundary_align got=timeout want=boundary reached");
    end
    for (int k = 0; k < 2 * FRAME + 2; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL boundary_load t=%0d got=%h want=%h", m_t, dut_vec, exp_vec);
      end
      if (frame_done) begin
        fd_seen++;
        total++;
        if (load_ready !== (fd_seen != 1)) begin
          bad++; $display("FAIL boundary_ready fd=%0d got=%b want=%b", fd_seen, load_ready, fd_seen != 1);
        end
      end
      prod_step();
    end
  endtask

  task automatic test_codes_and_lz(input logic [15:0] val, input logic [6:0] e3, input logic [6:0] e2,
                                   input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] es [4];
    es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
    q.push_back({4'b0000, val});
    clear_capture();
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL value_%h t=%0d got=%h want=%h", val, m_t, dut_vec, exp_vec);
      end
      if (k >= 2 * FRAME) capture();
      prod_step();
    end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (cap_seg[d] !== es[d] || cap_dp[d] !== 1'b1) begin
        bad++;
        $display("FAIL value_%h_dig%0d got seg_n=%h dp_n=%b want seg_n=%h dp_n=1", val, d, cap_seg[d], cap_dp[d], es[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL random t=%0d got=%h want=%h", m_t, dut_vec, exp_vec);
      end
      if (q.size() == 0 && $urandom_range(0, 9) == 0)
        q.push_back({4'($urandom_range(0, 15)), 16'($urandom)});
      prod_step();
    end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    q.push_back({4'b1111, 16'h8888});
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL pre_reset t=%0d got=%h want=%h", m_t, dut_vec, exp_vec);
      end
      prod_step();
      if (k >= 2 * FRAME && (m_t % FRAME) == 14) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit || dig_n !== 4'hB) begin
      bad++; $display("FAIL reset_digit2 got dig_n=%h want=b", dig_n);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1}) begin
      bad++; $display("FAIL async_reset got=%h want=%h", dut_vec, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b1});
    end
    q.delete();
    load_valid = 1'b0;
    was_ready  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < FRAME + 2; k++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec || (k == 0 && dig_n !== 4'hE)) begin
        bad++; $display("FAIL post_reset k=%0d got=%h want=%h", k, dut_vec, exp_vec);
      end
      prod_step();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_codes_and_lz(16'hFA90, 7'h7F, 7'h7F, ~7'h6F, ~7'h3F);
`ifdef LZ_BLANK_EN
    test_codes_and_lz(16'h0040, 7'h7F, 7'h7F, ~7'h66, ~7'h3F);
    test_codes_and_lz(16'h0000, 7'h7F, 7'h7F, 7'h7F, ~7'h3F);
`else
    test_codes_and_lz(16'h0040, ~7'h3F, ~7'h3F, ~7'h66, ~7'h3F);
    test_codes_and_lz(16'h0000, ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F);
`endif
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
